// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// A grant is held from address acceptance until the response handshake completes.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_avalid,
    output logic                ifu_aready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_dvalid,
    input  logic                ifu_dready,
    input  logic                lsu_avalid,
    output logic                lsu_aready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_dvalid,
    input  logic                lsu_dready,
    output logic                mem_avalid,
    input  logic                mem_aready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_dvalid,
    output logic                mem_dready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                owner_r;
    logic                last_grant_r;
    logic                winner_s;
    logic                accept_s;
    logic                owner_dready_s;
    logic [ADDR_W-1:0]   addr_r;
    logic                wen_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W/8-1:0] wmask_r;

    // Winner selection: sole requester wins; on a tie the one not granted last time wins.
    always_comb begin
        winner_s = OWN_IFU;
        if (ifu_avalid && lsu_avalid) begin
            winner_s = ~last_grant_r;
        end else if (lsu_avalid) begin
            winner_s = OWN_LSU;
        end else begin
            winner_s = OWN_IFU;
        end
    end

    // Next-state and handshake decode; aready and the response path are combinational.
    always_comb begin
        state_nxt_s    = state_r;
        ifu_aready     = 1'b0;
        lsu_aready     = 1'b0;
        ifu_dvalid     = 1'b0;
        lsu_dvalid     = 1'b0;
        mem_avalid     = 1'b0;
        mem_dready     = 1'b0;
        accept_s       = 1'b0;
        owner_dready_s = (owner_r == OWN_LSU) ? lsu_dready : ifu_dready;
        case (state_r)
            ST_IDLE: begin
                ifu_aready = ifu_avalid && (winner_s == OWN_IFU);
                lsu_aready = lsu_avalid && (winner_s == OWN_LSU);
                // aready always follows avalid for the winner, so any request is accepted here
                accept_s   = ifu_avalid || lsu_avalid;
                if (accept_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                mem_avalid = 1'b1;
                if (mem_aready) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_RESP: begin
                mem_dready = owner_dready_s;
                if (owner_r == OWN_LSU) begin
                    lsu_dvalid = mem_dvalid;
                end else begin
                    ifu_dvalid = mem_dvalid;
                end
                if (mem_dvalid && owner_dready_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, grant bookkeeping and request field capture on acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_IFU;
            last_grant_r <= OWN_LSU;
            addr_r       <= '0;
            wen_r        <= 1'b0;
            wdata_r      <= '0;
            wmask_r      <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                owner_r      <= winner_s;
                last_grant_r <= winner_s;
                if (winner_s == OWN_LSU) begin
                    addr_r  <= lsu_addr;
                    wen_r   <= lsu_wen;
                    wdata_r <= lsu_wdata;
                    wmask_r <= lsu_wmask;
                end else begin
                    addr_r  <= ifu_addr;
                    wen_r   <= 1'b0;
                    wdata_r <= '0;
                    wmask_r <= '0;
                end
            end
        end
    end

    assign mem_addr  = addr_r;
    assign mem_wen   = wen_r;
    assign mem_wdata = wdata_r;
    assign mem_wmask = wmask_r;
    assign ifu_rdata = mem_rdata;
    assign lsu_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store, round-robin contention, stalls and mid-response reset.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        ifu_avalid, ifu_aready, ifu_dvalid, ifu_dready;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_avalid, lsu_aready, lsu_wen, lsu_dvalid, lsu_dready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_avalid, mem_aready, mem_wen, mem_dvalid, mem_dready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int n_checks = 0;
    int n_pass   = 0;
    int fires;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .ifu_avalid(ifu_avalid), .ifu_aready(ifu_aready), .ifu_addr(ifu_addr),
        .ifu_rdata(ifu_rdata), .ifu_dvalid(ifu_dvalid), .ifu_dready(ifu_dready),
        .lsu_avalid(lsu_avalid), .lsu_aready(lsu_aready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rdata(lsu_rdata), .lsu_dvalid(lsu_dvalid), .lsu_dready(lsu_dready),
        .mem_avalid(mem_avalid), .mem_aready(mem_aready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata), .mem_dvalid(mem_dvalid), .mem_dready(mem_dready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs change 1 time unit after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        ifu_avalid = 1'b0; ifu_addr = 32'h0; ifu_dready = 1'b0;
        lsu_avalid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0;
        lsu_wdata = 32'h0; lsu_wmask = 4'h0; lsu_dready = 1'b0;
        mem_aready = 1'b0; mem_rdata = 32'h0; mem_dvalid = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        settle();
        // reset state
        chk("rst_mem_avalid", mem_avalid, 1'b0);
        chk("rst_ifu_dvalid", ifu_dvalid, 1'b0);
        chk("rst_lsu_dvalid", lsu_dvalid, 1'b0);
        chk("rst_mem_dready", mem_dready, 1'b0);
        chk("rst_mem_addr",   mem_addr, 32'h0);
        chk("rst_aready",     {ifu_aready, lsu_aready}, 2'b00);

        // IFU-only fetch, minimum latency
        ifu_avalid = 1'b1; ifu_addr = 32'h8000_0000; ifu_dready = 1'b1; mem_aready = 1'b1;
        settle();
        chk("f_ifu_aready", ifu_aready, 1'b1);
        chk("f_lsu_aready", lsu_aready, 1'b0);
        tick();
        ifu_avalid = 1'b0; settle();
        chk("f_mem_avalid", mem_avalid, 1'b1);
        chk("f_mem_addr",   mem_addr, 32'h8000_0000);
        chk("f_mem_wen",    mem_wen, 1'b0);
        chk("f_mem_wmask",  mem_wmask, 4'h0);
        tick();
        mem_dvalid = 1'b1; mem_rdata = 32'h0000_0413; settle();
        chk("f_ifu_dvalid", ifu_dvalid, 1'b1);
        chk("f_ifu_rdata",  ifu_rdata, 32'h0000_0413);
        chk("f_lsu_dvalid", lsu_dvalid, 1'b0);
        chk("f_mem_dready", mem_dready, 1'b1);
        chk("f_avalid_off", mem_avalid, 1'b0);
        tick();
        mem_dvalid = 1'b0; settle();
        chk("f_done", {ifu_dvalid, mem_avalid}, 2'b00);

        // LSU store
        idle_inputs();
        lsu_avalid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF; lsu_dready = 1'b1; mem_aready = 1'b1;
        settle();
        chk("s_lsu_aready", lsu_aready, 1'b1);
        chk("s_ifu_aready", ifu_aready, 1'b0);
        tick();
        lsu_avalid = 1'b0; settle();
        chk("s_mem_fields", {mem_avalid, mem_addr, mem_wen, mem_wdata, mem_wmask},
            {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF});
        chk("s_ifu_aready2", ifu_aready, 1'b0);
        tick();
        mem_dvalid = 1'b1; settle();
        chk("s_lsu_ack", {lsu_dvalid, ifu_dvalid, mem_dready}, 3'b101);
        chk("s_ifu_aready3", ifu_aready, 1'b0);
        tick();
        mem_dvalid = 1'b0; settle();
        chk("s_done", lsu_dvalid, 1'b0);

        // contention from reset: IFU, LSU, IFU, LSU
        idle_inputs();
        reset = 1'b1; tick(); reset = 1'b0;
        ifu_avalid = 1'b1; ifu_addr = 32'h0000_0100; ifu_dready = 1'b1;
        lsu_avalid = 1'b1; lsu_addr = 32'h0000_0200; lsu_dready = 1'b1;
        mem_aready = 1'b1; mem_dvalid = 1'b1; mem_rdata = 32'h1234_0000;
        for (int t = 0; t < 4; t++) begin
            logic exp_lsu;
            exp_lsu = logic'(t % 2);
            settle();
            chk("rr_grant", {ifu_aready, lsu_aready}, {~exp_lsu, exp_lsu});
            chk("rr_dv_idle", {ifu_dvalid, lsu_dvalid}, 2'b00);
            tick(); settle();
            chk("rr_addr", mem_addr, exp_lsu ? 32'h0000_0200 : 32'h0000_0100);
            chk("rr_busy", {ifu_aready, lsu_aready, mem_avalid}, 3'b001);
            tick(); settle();
            chk("rr_resp", {ifu_dvalid, lsu_dvalid}, {~exp_lsu, exp_lsu});
            tick();
        end

        // stalls: mem_aready low 3 cycles, then owner dready low 2 cycles
        idle_inputs();
        fires = 0;
        lsu_avalid = 1'b1; lsu_addr = 32'h0000_0300; lsu_wen = 1'b1;
        lsu_wdata = 32'h1234_5678; lsu_wmask = 4'h3;
        settle();
        chk("st_accept", lsu_aready, 1'b1);
        tick();
        lsu_avalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("st_req_hold", {mem_avalid, mem_addr, mem_wdata, mem_wmask},
                {1'b1, 32'h0000_0300, 32'h1234_5678, 4'h3});
            tick();
        end
        mem_aready = 1'b1; settle();
        chk("st_req_go", mem_avalid, 1'b1);
        tick();
        mem_aready = 1'b0; mem_dvalid = 1'b1; mem_rdata = 32'h0000_00AB;
        for (int c = 0; c < 3; c++) begin
            lsu_dready = (c == 2);
            settle();
            chk("st_resp_dv", lsu_dvalid, 1'b1);
            chk("st_resp_rdy", mem_dready, lsu_dready);
            chk("st_resp_addr", mem_addr, 32'h0000_0300);
            if (lsu_dvalid && lsu_dready) fires++;
            tick();
        end
        settle();
        chk("st_after_dv", lsu_dvalid, 1'b0);
        if (lsu_dvalid && lsu_dready) fires++;
        chk("st_one_fire", fires, 1);

        // reset while in RESP
        idle_inputs();
        tick();
        ifu_avalid = 1'b1; ifu_addr = 32'h0000_0500; mem_aready = 1'b1;
        tick();
        ifu_avalid = 1'b0; tick();
        mem_dvalid = 1'b1; settle();
        chk("rr0_in_resp", ifu_dvalid, 1'b1);
        reset = 1'b1; tick(); settle();
        chk("rr0_cleared", {ifu_dvalid, lsu_dvalid, mem_avalid, mem_dready}, 4'b0000);
        reset = 1'b0; mem_dvalid = 1'b0;
        lsu_avalid = 1'b1; lsu_addr = 32'h0000_0400; lsu_dready = 1'b1;
        settle();
        chk("rr0_new_acc", lsu_aready, 1'b1);
        tick();
        lsu_avalid = 1'b0; settle();
        chk("rr0_new_req", {mem_avalid, mem_addr, mem_wen}, {1'b1, 32'h0000_0400, 1'b0});
        tick();
        mem_dvalid = 1'b1; mem_rdata = 32'hCAFE_0001; settle();
        chk("rr0_new_rsp", {lsu_dvalid, lsu_rdata}, {1'b1, 32'hCAFE_0001});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single core memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). Each requester uses a valid/ready address channel and a valid/ready data/response channel. The arbiter grants one requester at a time and holds the grant until that transaction's response handshake completes. It sits between the IFU/LSU and the memory-side DPI/bus adapter.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; the write mask is DATA_W/8 bits
- clock  in  1  core clock; all logic is posedge
- reset  in  1  synchronous, active-high
- ifu_avalid  in  1  IFU fetch request valid
- ifu_aready  out  1  IFU request accepted
- ifu_addr  in  ADDR_W  fetch address
- ifu_rdata  out  DATA_W  fetched instruction
- ifu_dvalid  out  1  IFU response valid
- ifu_dready  in  1  IFU ready for response
- lsu_avalid  in  1  LSU request valid
- lsu_aready  out  1  LSU request accepted
- lsu_addr  in  ADDR_W  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  store byte mask
- lsu_rdata  out  DATA_W  load data
- lsu_dvalid  out  1  LSU response valid (load data or store ack)
- lsu_dready  in  1  LSU ready for response
- mem_avalid  out  1  memory request valid
- mem_aready  in  1  memory request accepted
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  as LSU  latched request fields
- mem_rdata  in  DATA_W  memory read data
- mem_dvalid  in  1  memory response valid
- mem_dready  out  1  arbiter ready for response

## Operation
- Registers: state (IDLE, REQ, RESP), owner (IFU/LSU), last_grant, and latched addr/wen/wdata/wmask.
- IDLE: the winner is the sole valid requester. If both are valid, the winner is the one not equal to last_grant (round-robin).
  - Winner's aready = 1, combinationally. Loser's aready = 0.
  - On winner afire: latch its fields (IFU forces wen=0, wmask=0), set owner = last_grant = winner, go to REQ.
- REQ: mem_avalid = 1 with latched fields. On mem_aready, go to RESP.
- RESP: owner's dvalid = mem_dvalid and mem_dready = owner's dready. On mem_dvalid & mem_dready, go to IDLE.
- Both rdata outputs are driven from mem_rdata. A non-owner's dvalid is always 0.
- Outside IDLE, both aready = 0. New requests wait and must hold valid and fields stable until accepted.
- Every transaction gets exactly one response, including stores (ack).

## Timing
- Reset values:
  - state = IDLE, last_grant = LSU (so the IFU wins the first tie).
  - owner = IFU; latched fields = 0.
  - All outputs 0, except that aready may assert in the same cycle a requester asserts valid after reset.
- Reset mid-transaction abandons the transaction with no response. The memory side is reset by the same signal.
- Minimum latency: afire at cycle N, mem_avalid at N+1, and with mem_aready=1 the response may appear at N+2 (combinational pass-through of mem_dvalid).
- Back-to-back: after response fire at cycle M, IDLE at M+1 can accept a new request in that cycle. Throughput is at most one transaction per 3 cycles.
- Response stall (owner dready=0): stay in RESP; mem_rdata/mem_dvalid are held by the memory side.
- mem_aready low: stay in REQ with fields stable.
- A request from the non-owner that arrives during a transaction is served next. Under contention, round-robin guarantees alternation.

## Test plan
- IFU-only fetch: ifu_addr=0x8000_0000 with mem returning 0x0000_0413 -> mem_addr=0x8000_0000, mem_wen=0; ifu_rdata=0x0000_0413 with ifu_dvalid at cycle N+2; lsu_dvalid stays 0.
- LSU store: addr 0x8000_1000, wdata 0xDEAD_BEEF, wmask 0xF -> mem fields match; lsu_dvalid ack; ifu_aready=0 throughout.
- Simultaneous requests held for 4 transactions starting from reset -> grant order IFU, LSU, IFU, LSU.
- Stalls: mem_aready low 3 cycles, then owner dready low 2 cycles -> state holds, mem fields stable, exactly one response fire.
- Reset asserted in RESP -> next cycle state IDLE, all dvalid 0, mem_avalid 0; the next request proceeds normally.
